seg_scan_capture: RTL and testbench
===================================

Name: seg_scan_capture

Overview:
Receive-side counterpart of the 2-to-4 digit decoder and BCD-to-7-segment decoder pair. Monitors a multiplexed 4-digit 7-segment display bus (one-hot digit select plus segment lines) and converts each segment glyph back to BCD. Stores one BCD value per digit position, flags undecodable glyphs, and pulses once for every complete 4-digit frame. Used as a display loopback checker and readback path.

Parameters:
STABLE_CYC, 4, consecutive identical samples required before capture; legal range 1..255; internal counter is 8 bits.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  [0:6]  segment lines a..g, active-high; seg_in[0]=a, seg_in[6]=g
dig_sel  input  [0:3]  digit select, active-high one-hot; dig_sel[i] selects digit i; all-zero = blank
bcd_out  output  16  captured digits; digit i at bits [4i+3:4i]
dig_err  output  4  bit i set when digit i's last capture was an invalid glyph
frame_valid  output  1  one-cycle pulse when all four digits captured since the last pulse
sel_err  output  1  one-cycle pulse when a sampled dig_sel has two or more bits set

Behaviour:
- Reset: asynchronous on rst_n low, with immediate effect including mid-dwell.
  - bcd_out=0, dig_err=0, frame_valid=0, sel_err=0.
  - Stability counter=0, previous-sample registers=0, seen mask=0, FSM=IDLE.
- Inputs are synchronous to clk. No input synchronizer.
- Glyph decode, seg_in[0:6] -> BCD:
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3, 0110011->4.
  - 1011011->5, 1011111->6, 1110000->7, 1111111->8, 1111011->9.
  - Any other pattern (including all-zero) is invalid -> BCD 4'hF, error bit 1.
- FSM states: IDLE, DWELL, HELD.
  - IDLE: dig_sel not one-hot; cnt=0.
    - A one-hot sample moves to DWELL with cnt=1.
    - If STABLE_CYC=1, capture on that same edge and go to HELD.
  - DWELL: each edge, compare (dig_sel, seg_in) against the previous sample.
    - Identical: cnt increments.
    - Different but one-hot: cnt=1 and stay in DWELL.
    - Not one-hot: go to IDLE with cnt=0.
    - When cnt reaches STABLE_CYC, capture on that edge and go to HELD.
  - HELD: identical samples cause no further capture (one capture per dwell).
    - Any change goes to DWELL (cnt=1) or IDLE, by the same rules as DWELL.
- Capture:
  - On the capturing edge, bcd_out[digit i] gets the decoded value and dig_err[i] gets the error bit.
  - Seen-mask bit i is set.
  - Outputs are visible right after the edge that takes the STABLE_CYC-th identical sample, not before.
- Frame:
  - If a capture makes the seen mask 4'b1111, frame_valid is high for exactly the following cycle.
  - The seen mask clears to 0 on that same edge; the completing bit is not retained.
  - Recapturing an already-seen digit updates its value but does not advance the frame.
- sel_err:
  - Registered pulse, high for the cycle after any edge sampling dig_sel with popcount >= 2.
  - Repeats every cycle the condition persists.
  - All-zero dig_sel is legal blanking: no sel_err, FSM goes to IDLE.
- Digits not yet captured keep their previous values; bcd_out is never cleared except by reset.

Test Plan:
- Defaults (STABLE_CYC=4).
- Reset: rst_n=0, any inputs -> bcd_out=16'h0000, dig_err=0, frame_valid=0, sel_err=0.
- Basic capture: dig_sel[0]=1, seg_in=1101101 held 4 edges -> bcd_out[3:0]=4'h2 after the 4th edge, still 0 after the 3rd; no recapture while held 10 more cycles.
- Glitch reject: dig_sel[1]=1, seg_in=1111001 for 3 edges, then 1111000 on the 4th -> no capture, bcd_out[7:4] unchanged. Holding 1111000 for 3 more edges -> bcd_out[7:4]=4'hF, dig_err[1]=1.
- Full frame: digits 0..3 show glyphs 1,2,3,4, each held 6 cycles with 2 blank cycles between -> bcd_out=16'h4321, dig_err=0. frame_valid high exactly one cycle, right after digit 3's capture edge; seen mask cleared.
- Select error: dig_sel[0]=dig_sel[2]=1 for 3 cycles -> sel_err high 3 cycles, no capture, FSM in IDLE. A following valid one-hot dwell of 4 edges captures normally.
- Reset mid-operation: rst_n pulsed low after 2 edges of a dwell on digit 3 with glyph 8 -> all outputs 0 immediately. After release, a full 4-edge dwell is needed before bcd_out[15:12]=4'h8.

Source files
------------

// File: rtl/seg_scan_capture.sv
`timescale 1ns/1ps
// Purpose: decode a multiplexed 4-digit 7-segment bus back to BCD, one value per digit.
// Latency: capture visible right after the edge taking the STABLE_CYC-th identical sample.
// Backpressure: none; passive bus monitor, every cycle is sampled.
//
// Ports:
//   clk, rst_n   - clock (rising edge) and async active-low reset
//   seg_in[0:6]  - segment lines a..g, active-high (seg_in[0] = a)
//   dig_sel[0:3] - one-hot digit select, all-zero = blank
//   bcd_out      - captured digits, digit i at [4i+3:4i]
//   dig_err      - bit i set when digit i's last capture was not a valid glyph
//   frame_valid  - one-cycle pulse when all four digits have been captured
//   sel_err      - one-cycle pulse after sampling a dig_sel with 2+ bits set
module seg_scan_capture #(
  parameter int unsigned STABLE_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:6]  seg_in,
  input  logic [0:3]  dig_sel,
  output logic [15:0] bcd_out,
  output logic [3:0]  dig_err,
  output logic        frame_valid,
  output logic        sel_err
);

  localparam logic [7:0] STABLE_N = STABLE_CYC[7:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    HELD  = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt, cnt_nxt;
  logic [0:3]  prev_sel;
  logic [0:6]  prev_seg;
  logic [3:0]  seen;

  logic [2:0]  sel_pop;
  logic        one_hot;
  logic        multi_sel;
  logic        same;
  logic        cap;
  logic [1:0]  dig_idx;
  logic [3:0]  dec_bcd;
  logic        dec_err;
  logic [3:0]  seen_upd;

  // Select classification and digit index.
  always_comb begin
    sel_pop = 3'd0;
    dig_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      sel_pop = sel_pop + {2'b00, dig_sel[i]};
      if (dig_sel[i]) dig_idx = 2'(i);
    end
  end

  assign one_hot   = (sel_pop == 3'd1);
  assign multi_sel = (sel_pop >= 3'd2);
  assign same      = (dig_sel == prev_sel) && (seg_in == prev_seg);

  // Glyph to BCD; vector order is a..g from MSB to LSB.
  always_comb begin
    dec_err = 1'b0;
    case (seg_in)
      7'b1111110: dec_bcd = 4'd0;
      7'b0110000: dec_bcd = 4'd1;
      7'b1101101: dec_bcd = 4'd2;
      7'b1111001: dec_bcd = 4'd3;
      7'b0110011: dec_bcd = 4'd4;
      7'b1011011: dec_bcd = 4'd5;
      7'b1011111: dec_bcd = 4'd6;
      7'b1110000: dec_bcd = 4'd7;
      7'b1111111: dec_bcd = 4'd8;
      7'b1111011: dec_bcd = 4'd9;
      default: begin
        dec_bcd = 4'hF;
        dec_err = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state. A new one-hot sample (from any state) opens a dwell at count 1;
  // with STABLE_CYC=1 that first sample already completes the dwell.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap       = 1'b0;
    if (!one_hot) begin
      state_nxt = IDLE;
      cnt_nxt   = 8'd0;
    end else if (state != IDLE && same) begin
      if (state == DWELL) begin
        cnt_nxt = cnt + 8'd1;
        if (cnt_nxt == STABLE_N) begin
          cap       = 1'b1;
          state_nxt = HELD;
        end
      end
      // HELD with an unchanged sample: one capture per dwell, nothing to do.
    end else begin
      cnt_nxt = 8'd1;
      if (STABLE_N == 8'd1) begin
        cap       = 1'b1;
        state_nxt = HELD;
      end else begin
        state_nxt = DWELL;
      end
    end
  end

  assign seen_upd = seen | (4'b0001 << dig_idx);

  // Sample history, captured digits and frame tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_sel    <= 4'b0000;
      prev_seg    <= 7'b0000000;
      bcd_out     <= 16'h0000;
      dig_err     <= 4'b0000;
      seen        <= 4'b0000;
      frame_valid <= 1'b0;
      sel_err     <= 1'b0;
    end else begin
      prev_sel    <= dig_sel;
      prev_seg    <= seg_in;
      sel_err     <= multi_sel;
      frame_valid <= 1'b0;
      if (cap) begin
        bcd_out[{dig_idx, 2'b00} +: 4] <= dec_bcd;
        dig_err[dig_idx]               <= dec_err;
        // The completing bit is dropped so the next frame starts empty.
        if (seen_upd == 4'b1111) begin
          seen        <= 4'b0000;
          frame_valid <= 1'b1;
        end else begin
          seen <= seen_upd;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
`timescale 1ns/1ps
module tb_seg_scan_capture;

  localparam int N = 4;

  logic        clk;
  logic        rst_n;
  logic [0:6]  seg_in;
  logic [0:3]  dig_sel;
  logic [15:0] bcd_out;
  logic [3:0]  dig_err;
  logic        frame_valid;
  logic        sel_err;

  int checks = 0;
  int errors = 0;

  seg_scan_capture #(.STABLE_CYC(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .bcd_out     (bcd_out),
    .dig_err     (dig_err),
    .frame_valid (frame_valid),
    .sel_err     (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a digit is captured when a run of identical one-hot
  // samples reaches exactly N long.
  logic [0:6] glyphs [0:9] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                               7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                               7'b1111111, 7'b1111011};
  logic [3:0] m_bcd [0:3];
  logic       m_err [0:3];
  logic [3:0] m_seen;
  logic       m_fv, m_se;
  logic [0:3] last_sel;
  logic [0:6] last_seg;
  int         run;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_bcd[i] = 4'h0;
      m_err[i] = 1'b0;
    end
    m_seen = 4'b0; m_fv = 1'b0; m_se = 1'b0;
    last_sel = '0; last_seg = '0; run = 0;
  endtask

  task automatic model_edge(input logic [0:3] s, input logic [0:6] g);
    int idx, val;
    m_fv = 1'b0;
    m_se = ($countones(s) >= 2);
    if ($countones(s) == 1) begin
      if (s == last_sel && g == last_seg) run++;
      else run = 1;
      if (run == N) begin
        idx = 0;
        for (int i = 0; i < 4; i++) if (s[i]) idx = i;
        val = 15;
        for (int d = 0; d < 10; d++) if (g == glyphs[d]) val = d;
        m_bcd[idx] = 4'(val);
        m_err[idx] = (val == 15);
        m_seen[idx] = 1'b1;
        if (m_seen == 4'b1111) begin
          m_fv = 1'b1;
          m_seen = 4'b0;
        end
      end
    end else begin
      run = 0;
    end
    last_sel = s;
    last_seg = g;
  endtask

  task automatic check_all(input string tag);
    logic [15:0] eb;
    logic [3:0]  ee;
    eb = {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
    for (int i = 0; i < 4; i++) ee[i] = m_err[i];
    checks++;
    assert (bcd_out === eb) else begin
      errors++; $error("FAIL %s bcd_out got %h exp %h", tag, bcd_out, eb);
    end
    checks++;
    assert (dig_err === ee) else begin
      errors++; $error("FAIL %s dig_err got %b exp %b", tag, dig_err, ee);
    end
    checks++;
    assert (frame_valid === m_fv) else begin
      errors++; $error("FAIL %s frame_valid got %b exp %b", tag, frame_valid, m_fv);
    end
    checks++;
    assert (sel_err === m_se) else begin
      errors++; $error("FAIL %s sel_err got %b exp %b", tag, sel_err, m_se);
    end
  endtask

  // Inputs change 1ns after an edge; outputs are checked 1ns after the next edge.
  task automatic step(input logic [0:3] s, input logic [0:6] g, input string tag);
    dig_sel = s;
    seg_in  = g;
    @(posedge clk);
    model_edge(s, g);
    #1;
    check_all(tag);
  endtask

  initial begin
    int fv_cnt;
    logic [0:3] s;
    logic [0:6] g;
    int hold;

    rst_n = 1'b0; dig_sel = '0; seg_in = 7'b1111111;
    model_reset();
    #3 check_all("reset");
    @(posedge clk); #1 rst_n = 1'b1;

    // Basic capture on digit 0 with glyph 2, then held 10 more cycles.
    for (int k = 0; k < 14; k++) step(4'b1000, 7'b1101101, "basic");
    checks++;
    assert (bcd_out[3:0] === 4'h2) else begin
      errors++; $error("FAIL basic_val got %h exp 2", bcd_out[3:0]);
    end

    // Glitch on the 4th sample, then the new pattern dwells to an invalid capture.
    step(4'b0000, 7'b0000000, "gap");
    for (int k = 0; k < 3; k++) step(4'b0100, 7'b1111001, "glitch_pre");
    for (int k = 0; k < 4; k++) step(4'b0100, 7'b1111000, "glitch_post");
    checks++;
    assert (bcd_out[7:4] === 4'hF && dig_err[1] === 1'b1) else begin
      errors++; $error("FAIL glitch_val got %h/%b exp F/1", bcd_out[7:4], dig_err[1]);
    end

    // Full frame: glyphs 1..4 on digits 0..3, 6 cycles each, 2 blank between.
    fv_cnt = 0;
    for (int d = 0; d < 4; d++) begin
      s = 4'b1000 >> d;
      for (int k = 0; k < 6; k++) begin
        step(s, glyphs[d + 1], "frame");
        if (frame_valid) fv_cnt++;
      end
      for (int k = 0; k < 2; k++) begin
        step(4'b0000, 7'b0000000, "frame_blank");
        if (frame_valid) fv_cnt++;
      end
    end
    checks++;
    assert (bcd_out === 16'h4321 && dig_err === 4'b0000) else begin
      errors++; $error("FAIL frame_val got %h/%b exp 4321/0000", bcd_out, dig_err);
    end
    checks++;
    assert (fv_cnt == 1) else begin
      errors++; $error("FAIL frame_pulses got %0d exp 1", fv_cnt);
    end

    // Multi-bit select for 3 cycles, then a normal dwell on digit 2.
    for (int k = 0; k < 3; k++) step(4'b1010, 7'b1111110, "selerr");
    for (int k = 0; k < 5; k++) step(4'b0010, 7'b1011111, "after_selerr");

    // Reset in the middle of a dwell on digit 3.
    for (int k = 0; k < 2; k++) step(4'b0001, 7'b1111111, "pre_rst");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("mid_reset");
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step(4'b0001, 7'b1111111, "post_rst");
    checks++;
    assert (bcd_out[15:12] === 4'h8) else begin
      errors++; $error("FAIL post_rst_val got %h exp 8", bcd_out[15:12]);
    end

    // Randomized dwells, blanks, select errors and glitches.
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0: s = 4'b0000;
        1: begin
          s = 4'($urandom_range(0, 15));
          while ($countones(s) < 2) s = 4'($urandom_range(0, 15));
        end
        default: s = 4'b1000 >> $urandom_range(0, 3);
      endcase
      if ($urandom_range(0, 4) == 0) g = 7'($urandom);
      else g = glyphs[$urandom_range(0, 9)];
      hold = $urandom_range(1, 7);
      for (int k = 0; k < hold; k++) begin
        if ($urandom_range(0, 15) == 0) step(s, g ^ 7'b0000100, "rand_glitch");
        else step(s, g, "rand");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
